// File: rtl/aoc4_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// aoc4_sweep_ctrl
//
// Sequencer for the 3-bank grid row memory of the day-4 datapath. The block
// streams rows into memory and then sweeps every row. For each row it issues a
// parallel 3-row read centred on that row, hands the window to the
// neighbour-count unit, and writes the updated row back in place. Full sweeps
// repeat until a pass reports no change or the pass cap is reached. Row data
// never passes through this block. It drives only the memory address, the
// memory strobes and the handshakes.
//
// Ports
//   clock, reset        : system clock, asynchronous active-high reset
//   start               : begin a load; ignored while busy
//   busy / done         : busy while not idle; done pulses for one cycle at the end
//   pass_count          : completed sweeps; held after done until the next start
//   rows_loaded         : number of rows accepted from the load stream
//   err_overflow        : sticky; the load stream was truncated at MAX_ROWS
//   in_valid/in_last/in_ready          : load stream handshake
//   mem_addr/mem_write_en/mem_read_en/mem_parallel_read : memory control
//   win_valid/win_ready/win_row/win_top_edge/win_bot_edge : window handshake
//   wb_valid/wb_changed/wb_ready       : writeback handshake
// -----------------------------------------------------------------------------
module aoc4_sweep_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_ROWS   = 140,
    parameter int READ_LAT   = 2,
    parameter int MAX_PASSES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            pass_count,
    output logic [ADDR_WIDTH-1:0] rows_loaded,
    output logic                  err_overflow,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic                  mem_parallel_read,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [ADDR_WIDTH-1:0] win_row,
    output logic                  win_top_edge,
    output logic                  win_bot_edge,
    input  logic                  wb_valid,
    input  logic                  wb_changed,
    output logic                  wb_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WIN,
        S_WB,
        S_PASS_END,
        S_DONE
    } state_t;

    localparam int                    WAIT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [WAIT_W-1:0]     WAIT_INIT = WAIT_W'(READ_LAT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(MAX_ROWS - 1);
    localparam logic [7:0]            PASS_CAP  = 8'(MAX_PASSES);

    state_t                  state_q,       state_d;
    logic [ADDR_WIDTH-1:0]   row_cnt_q,     row_cnt_d;
    logic [ADDR_WIDTH-1:0]   r_q,           r_d;
    logic [ADDR_WIDTH-1:0]   n_rows_q,      n_rows_d;
    logic                    changed_q,     changed_d;
    logic [WAIT_W-1:0]       wait_q,        wait_d;
    logic [7:0]              pass_count_q,  pass_count_d;
    logic                    err_q,         err_d;

    // NOTE: state registers take non-blocking assignments only. The next
    // values are all formed in the combinational process below.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_cnt_q    <= '0;
            r_q          <= '0;
            n_rows_q     <= '0;
            changed_q    <= 1'b0;
            wait_q       <= '0;
            pass_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            r_q          <= r_d;
            n_rows_q     <= n_rows_d;
            changed_q    <= changed_d;
            wait_q       <= wait_d;
            pass_count_q <= pass_count_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        // NOTE: every signal written in this process gets a default first. No
        // path through the case statement can leave a signal unassigned, so
        // no latch is inferred.
        state_d           = state_q;
        row_cnt_d         = row_cnt_q;
        r_d               = r_q;
        n_rows_d          = n_rows_q;
        changed_d         = changed_q;
        wait_d            = wait_q;
        pass_count_d      = pass_count_q;
        err_d             = err_q;
        done              = 1'b0;
        in_ready          = 1'b0;
        mem_addr          = '0;
        mem_write_en      = 1'b0;
        mem_read_en       = 1'b0;
        mem_parallel_read = 1'b0;
        win_valid         = 1'b0;
        win_row           = '0;
        win_top_edge      = 1'b0;
        win_bot_edge      = 1'b0;
        wb_ready          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_cnt_d    = '0;
                    pass_count_d = '0;
                    err_d        = 1'b0;
                    state_d      = S_LOAD;
                end
            end

            S_LOAD: begin
                in_ready = 1'b1;
                mem_addr = row_cnt_q;
                if (in_valid) begin
                    mem_write_en = 1'b1;
                    row_cnt_d    = row_cnt_q + 1'b1;
                    // A beat landing in the last slot ends the load, even
                    // when the stream has more rows to send.
                    if (in_last || row_cnt_q == LAST_SLOT) begin
                        n_rows_d  = row_cnt_q + 1'b1;
                        r_d       = '0;
                        changed_d = 1'b0;
                        state_d   = S_RD_ISSUE;
                        if (!in_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            S_RD_ISSUE: begin
                mem_read_en       = 1'b1;
                mem_parallel_read = 1'b1;
                mem_addr          = r_q;
                wait_d            = WAIT_INIT;
                state_d           = (READ_LAT > 1) ? S_RD_WAIT : S_WIN;
            end

            S_RD_WAIT: begin
                // The counter counts down to zero and the FSM leaves on the
                // cycle that sees zero. The window is therefore presented
                // one cycle after the read data becomes valid.
                mem_addr = r_q;
                if (wait_q == '0) begin
                    state_d = S_WIN;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            S_WIN: begin
                // Under backpressure the FSM holds here and keeps the address
                // stable. The read is not issued again.
                win_valid    = 1'b1;
                win_row      = r_q;
                win_top_edge = (r_q == '0);
                win_bot_edge = (r_q == n_rows_q - 1'b1);
                mem_addr     = r_q;
                if (win_ready) begin
                    state_d = S_WB;
                end
            end

            S_WB: begin
                wb_ready = 1'b1;
                mem_addr = r_q;
                if (wb_valid) begin
                    // The row is written back in place, so the window for
                    // r+1 already sees the updated row r.
                    mem_write_en = wb_changed;
                    changed_d    = changed_q | wb_changed;
                    if (r_q == n_rows_q - 1'b1) begin
                        state_d = S_PASS_END;
                    end else begin
                        r_d     = r_q + 1'b1;
                        state_d = S_RD_ISSUE;
                    end
                end
            end

            S_PASS_END: begin
                mem_addr     = r_q;
                pass_count_d = (pass_count_q == PASS_CAP) ? pass_count_q
                                                          : pass_count_q + 8'd1;
                if (changed_q && pass_count_d < PASS_CAP) begin
                    r_d       = '0;
                    changed_d = 1'b0;
                    state_d   = S_RD_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign pass_count   = pass_count_q;
    assign rows_loaded  = row_cnt_q;
    assign err_overflow = err_q;

endmodule
